steer_quad_encoder: RTL and testbench



---
 rtl/steer_quad_encoder.sv | 161 ++++++++++++++++
 tb/tb_steer_quad_encoder.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/steer_quad_encoder.sv
// ---------------------------------------------------------------------------
// steer_quad_encoder
//
// Turns digital left/right steering requests (USB or DB9/DB15 joystick) into
// the 2-bit quadrature pattern the Sprint 2 core expects on its Steer_xA and
// Steer_xB inputs. Holding a direction starts at a slow step rate. The rate
// then speeds up linearly until it reaches a fast limit, so short taps still
// give fine control. Use one instance per player, clocked from the 6 MHz
// video clock domain.
//
// Ports:
//   CLK         in   1  block clock (core 6 MHz)
//   reset       in   1  synchronous, active-high reset (acts even when ce=0)
//   ce          in   1  clock enable; all state holds while low
//   right       in   1  steer-right request, active high
//   left        in   1  steer-left request, active high
//   steer       out  2  quadrature output, [1]=A, [0]=B
//   dir         out  1  current/last direction, 1=right, 0=left
//   moving      out  1  high while the encoder is stepping (RUN state)
//   step_pulse  out  1  one-CLK strobe in the cycle steer shows a new phase
// ---------------------------------------------------------------------------
module steer_quad_encoder #(
    parameter int CW        = 16,
    parameter int DIV_MAX   = 22500,
    parameter int DIV_MIN   = 5625,
    parameter int RAMP_STEP = 1125
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       ce,
    input  logic       right,
    input  logic       left,
    output logic [1:0] steer,
    output logic       dir,
    output logic       moving,
    output logic       step_pulse
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [CW-1:0] DIV_MAX_W   = CW'(DIV_MAX);
    localparam logic [CW-1:0] DIV_MIN_W   = CW'(DIV_MIN);
    localparam logic [CW:0]   RAMP_STEP_W = (CW+1)'(RAMP_STEP);

    state_t        state_q;
    logic          r_q;
    logic          l_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] period_q;
    logic [1:0]    steer_q;
    logic          dir_q;
    logic          moving_q;
    logic          pulse_q;

    logic          reqRight;
    logic          reqLeft;
    logic [1:0]    steer_d;
    logic [CW:0]   rampDiff;
    logic [CW-1:0] period_d;

    // Requests come from the registered inputs. Pressing both directions
    // cancels out and is treated as no request.
    assign reqRight = r_q & ~l_q;
    assign reqLeft  = l_q & ~r_q;

    // Next Gray-code phase in the current direction. Right walks
    // 00->01->11->10 and left walks the same ring backwards, so each step
    // changes exactly one bit.
    always_comb begin
        steer_d = steer_q;
        case ({dir_q, steer_q})
            3'b1_00: steer_d = 2'b01;
            3'b1_01: steer_d = 2'b11;
            3'b1_11: steer_d = 2'b10;
            3'b1_10: steer_d = 2'b00;
            3'b0_00: steer_d = 2'b10;
            3'b0_10: steer_d = 2'b11;
            3'b0_11: steer_d = 2'b01;
            3'b0_01: steer_d = 2'b00;
        endcase
    end

    // Acceleration: each step shortens the period by RAMP_STEP, down to
    // DIV_MIN. The subtraction uses one extra bit so a large RAMP_STEP shows
    // up as a borrow and cannot wrap to a huge period.
    assign rampDiff = {1'b0, period_q} - RAMP_STEP_W;

    always_comb begin
        period_d = rampDiff[CW-1:0];
        if (rampDiff[CW] || (rampDiff[CW-1:0] < DIV_MIN_W)) begin
            period_d = DIV_MIN_W;
        end
    end

    // Main sequencer. The step strobe is cleared on every edge, ce or not,
    // so it lasts exactly one CLK even when ce runs slower than CLK.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= IDLE;
            r_q      <= 1'b0;
            l_q      <= 1'b0;
            cnt_q    <= '0;
            period_q <= DIV_MAX_W;
            steer_q  <= 2'b00;
            dir_q    <= 1'b0;
            moving_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (ce) begin
                r_q <= right;
                l_q <= left;
                case (state_q)
                    IDLE: begin
                        cnt_q    <= '0;
                        period_q <= DIV_MAX_W;
                        if (reqRight || reqLeft) begin
                            state_q  <= RUN;
                            moving_q <= 1'b1;
                            dir_q    <= reqRight;
                        end
                    end
                    RUN: begin
                        if (!reqRight && !reqLeft) begin
                            // Let go: stop here and keep the current phase.
                            state_q  <= IDLE;
                            moving_q <= 1'b0;
                            cnt_q    <= '0;
                            period_q <= DIV_MAX_W;
                        end else if (reqRight != dir_q) begin
                            // Reversal restarts at the slow rate with no step.
                            dir_q    <= reqRight;
                            cnt_q    <= '0;
                            period_q <= DIV_MAX_W;
                        end else if (cnt_q == period_q - 1'b1) begin
                            steer_q  <= steer_d;
                            pulse_q  <= 1'b1;
                            cnt_q    <= '0;
                            period_q <= period_d;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        moving_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign steer      = steer_q;
    assign dir        = dir_q;
    assign moving     = moving_q;
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_steer_quad_encoder.sv
// ---------------------------------------------------------------------------
// tb_steer_quad_encoder
//
// Self-checking bench for steer_quad_encoder. It uses small parameters so
// the acceleration ramp finishes within a few dozen cycles. The reference
// model tracks the shaft as a position 0..3 on the quadrature ring and counts
// the ce cycles that have passed since the last step or since the run began.
// ---------------------------------------------------------------------------
module tb_steer_quad_encoder;

    localparam int CW        = 8;
    localparam int DIV_MAX   = 8;
    localparam int DIV_MIN   = 2;
    localparam int RAMP_STEP = 3;

    logic       CLK;
    logic       reset;
    logic       ce;
    logic       right;
    logic       left;
    logic [1:0] steer;
    logic       dir;
    logic       moving;
    logic       step_pulse;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model state
    logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int  mPos;
    bit  mDir;
    bit  mRun;
    bit  mPulse;
    bit  mSampR;
    bit  mSampL;
    int  mElapsed;
    int  mPeriod;

    steer_quad_encoder #(
        .CW(CW),
        .DIV_MAX(DIV_MAX),
        .DIV_MIN(DIV_MIN),
        .RAMP_STEP(RAMP_STEP)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .ce(ce),
        .right(right),
        .left(left),
        .steer(steer),
        .dir(dir),
        .moving(moving),
        .step_pulse(step_pulse)
    );

    // 100 MHz-style free-running clock; only relative timing matters here
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Behavioural model advanced once per CLK edge with the inputs seen there
    task automatic modelTick(input bit rst, input bit en, input bit r, input bit l);
        bit wantR;
        bit wantL;
        if (rst) begin
            mPos     = 0;
            mDir     = 1'b0;
            mRun     = 1'b0;
            mPulse   = 1'b0;
            mSampR   = 1'b0;
            mSampL   = 1'b0;
            mElapsed = 0;
            mPeriod  = DIV_MAX;
        end else begin
            wantR  = mSampR && !mSampL;
            wantL  = mSampL && !mSampR;
            mPulse = 1'b0;
            if (en) begin
                mSampR = r;
                mSampL = l;
                if (!mRun) begin
                    if (wantR || wantL) begin
                        mRun     = 1'b1;
                        mDir     = wantR;
                        mElapsed = 0;
                        mPeriod  = DIV_MAX;
                    end
                end else if (!wantR && !wantL) begin
                    mRun = 1'b0;
                end else if (wantR != mDir) begin
                    mDir     = wantR;
                    mElapsed = 0;
                    mPeriod  = DIV_MAX;
                end else begin
                    mElapsed++;
                    if (mElapsed == mPeriod) begin
                        mPos     = (mPos + (mDir ? 1 : 3)) % 4;
                        mPulse   = 1'b1;
                        mElapsed = 0;
                        mPeriod  = (mPeriod - RAMP_STEP < DIV_MIN) ? DIV_MIN : mPeriod - RAMP_STEP;
                    end
                end
            end
        end
    endtask

    function automatic logic [4:0] expVec();
        return {gray[mPos], mDir, mRun, mPulse};
    endfunction

    // Drive one CLK cycle of inputs, advance the model and leave the
    // outputs settled #1 after the active edge for sampling
    task automatic applyStimulus(input bit rst, input bit en, input bit r, input bit l);
        reset = rst;
        ce    = en;
        right = r;
        left  = l;
        @(posedge CLK);
        modelTick(rst, en, r, l);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        nCompared++;
        if ({steer, dir, moving, step_pulse} !== 5'b00_0_0_0) begin
            nMismatched++;
            $display("[TB] FAIL reset_state got=%b exp=%b", {steer, dir, moving, step_pulse}, 5'b00_0_0_0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        nCompared++;
        if ({steer, dir, moving, step_pulse} !== expVec()) begin
            nMismatched++;
            $display("[TB] FAIL reset_idle got=%b exp=%b", {steer, dir, moving, step_pulse}, expVec());
        end
    endtask

    // Hold one direction: model check every cycle plus fixed pulse timing
    task automatic test_hold(input bit goRight);
        int         expGap [5] = '{9, 5, 2, 2, 2};
        logic [1:0] seqR   [5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
        logic [1:0] seqL   [5] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
        logic [1:0] want;
        int pulses = 0;
        int lastT  = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 41; t++) begin
            applyStimulus(1'b0, 1'b1, goRight, !goRight);
            nCompared++;
            if ({steer, dir, moving, step_pulse} !== expVec()) begin
                nMismatched++;
                $display("[TB] FAIL hold_%s_cycle t=%0d got=%b exp=%b", goRight ? "right" : "left",
                         t, {steer, dir, moving, step_pulse}, expVec());
            end
            if (step_pulse === 1'b1 && pulses < 5) begin
                want = goRight ? seqR[pulses] : seqL[pulses];
                nCompared++;
                if ((t - lastT) != expGap[pulses] || steer !== want) begin
                    nMismatched++;
                    $display("[TB] FAIL hold_%s_step%0d gap=%0d steer=%b exp gap=%0d steer=%b",
                             goRight ? "right" : "left", pulses, t - lastT, steer, expGap[pulses], want);
                end
                lastT = t;
                pulses++;
            end
        end
        nCompared++;
        if (pulses != 5) begin
            nMismatched++;
            $display("[TB] FAIL hold_%s_count got=%0d exp=5", goRight ? "right" : "left", pulses);
        end
    endtask

    task automatic test_reversal();
        int firstT = -1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 17; t++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
            nCompared++;
            if ({steer, dir, moving, step_pulse} !== expVec()) begin
                nMismatched++;
                $display("[TB] FAIL reversal_right t=%0d got=%b exp=%b", t, {steer, dir, moving, step_pulse}, expVec());
            end
        end
        for (int t = 0; t < 20; t++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
            nCompared++;
            if ({steer, dir, moving, step_pulse} !== expVec()) begin
                nMismatched++;
                $display("[TB] FAIL reversal_left t=%0d got=%b exp=%b", t, {steer, dir, moving, step_pulse}, expVec());
            end
            if (step_pulse === 1'b1 && firstT < 0) begin
                firstT = t;
            end
        end
        // Three right steps leave phase 10, and the first left step then goes to 11
        nCompared++;
        if (firstT != 9) begin
            nMismatched++;
            $display("[TB] FAIL reversal_first_step got t=%0d exp t=9", firstT);
        end
    endtask

    task automatic test_both_held();
        int pulseSeen = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 50; t++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
            pulseSeen += int'(step_pulse === 1'b1);
            nCompared++;
            if ({steer, dir, moving, step_pulse} !== expVec() || moving !== 1'b0 || steer !== 2'b00) begin
                nMismatched++;
                $display("[TB] FAIL both_held t=%0d got=%b exp=%b", t, {steer, dir, moving, step_pulse}, expVec());
            end
        end
        nCompared++;
        if (pulseSeen != 0) begin
            nMismatched++;
            $display("[TB] FAIL both_held_pulses got=%0d exp=0", pulseSeen);
        end
    endtask

    task automatic test_ce_half();
        int expGap [4] = '{18, 10, 4, 4};
        int pulses = 0;
        int lastT  = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 40; t++) begin
            applyStimulus(1'b0, (t % 2) == 0, 1'b1, 1'b0);
            nCompared++;
            if ({steer, dir, moving, step_pulse} !== expVec()) begin
                nMismatched++;
                $display("[TB] FAIL ce_half_cycle t=%0d got=%b exp=%b", t, {steer, dir, moving, step_pulse}, expVec());
            end
            if (step_pulse === 1'b1 && pulses < 4) begin
                nCompared++;
                if ((t - lastT) != expGap[pulses]) begin
                    nMismatched++;
                    $display("[TB] FAIL ce_half_gap%0d got=%0d exp=%0d", pulses, t - lastT, expGap[pulses]);
                end
                lastT = t;
                pulses++;
            end
        end
        nCompared++;
        if (pulses != 4) begin
            nMismatched++;
            $display("[TB] FAIL ce_half_count got=%0d exp=4", pulses);
        end
    endtask

    task automatic test_reset_midrun();
        int firstT = -1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 12; t++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        nCompared++;
        if ({steer, dir, moving, step_pulse} !== 5'b00_0_0_0) begin
            nMismatched++;
            $display("[TB] FAIL reset_midrun_state got=%b exp=%b", {steer, dir, moving, step_pulse}, 5'b00_0_0_0);
        end
        for (int t = 0; t < 20; t++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
            nCompared++;
            if ({steer, dir, moving, step_pulse} !== expVec()) begin
                nMismatched++;
                $display("[TB] FAIL reset_midrun_cycle t=%0d got=%b exp=%b", t, {steer, dir, moving, step_pulse}, expVec());
            end
            if (step_pulse === 1'b1 && firstT < 0) begin
                firstT = t;
            end
        end
        nCompared++;
        if (firstT != 9) begin
            nMismatched++;
            $display("[TB] FAIL reset_midrun_first_step got t=%0d exp t=9", firstT);
        end
    endtask

    // Random segments of none/right/left/both with a sparse ce and rare resets
    task automatic test_random();
        int  mode = 0;
        int  segLeft = 0;
        bit  r;
        bit  l;
        bit  en;
        bit  rst;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 3000; t++) begin
            if (segLeft == 0) begin
                mode    = int'($urandom_range(0, 3));
                segLeft = int'($urandom_range(1, 40));
            end
            segLeft--;
            r   = (mode == 1) || (mode == 3);
            l   = (mode == 2) || (mode == 3);
            en  = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 199) == 0;
            applyStimulus(rst, en, r, l);
            nCompared++;
            if ({steer, dir, moving, step_pulse} !== expVec()) begin
                nMismatched++;
                $display("[TB] FAIL random t=%0d got=%b exp=%b", t, {steer, dir, moving, step_pulse}, expVec());
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        ce    = 1'b0;
        right = 1'b0;
        left  = 1'b0;
        modelTick(1'b1, 1'b0, 1'b0, 1'b0);
        $display("[TB] starting steer_quad_encoder bench");
        test_reset();
        test_hold(1'b1);
        test_hold(1'b0);
        test_reversal();
        test_both_held();
        test_ce_half();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
